// File: rtl/serial_ripple_adder_if.sv
// Start/done handshake and operand/result bus
// for the digit-serial ripple adder.
interface serial_ripple_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_ripple_adder.sv
// Digit-serial ripple-carry adder: DIGIT bits per
// cycle through one shared DIGIT-bit adder chain.
module serial_ripple_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic             clk,
  input logic             rst_n,
  serial_ripple_adder_if.slave bus
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [WIDTH-1:0] MASK =
    WIDTH'({DIGIT{1'b1}});

  if (WIDTH < 1 || DIGIT < 1 || WIDTH % DIGIT != 0)
  begin : g_bad_params
    $error("DIGIT must divide WIDTH");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  int               base;
  logic             last;
  logic [DIGIT-1:0] da, db, ps;
  logic             co;

  // The current digit is shifted down to bit 0 and
  // the partial sum shifted back into its slice.
  always_comb begin
    base = int'(cnt_q) * DIGIT;
    last = (int'(cnt_q) == STEPS - 1);
    da   = DIGIT'(a_q >> base);
    db   = DIGIT'(b_q >> base);
    {co, ps} = {1'b0, da} + {1'b0, db}
             + {{DIGIT{1'b0}}, c_q};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          c_d     = bus.cin;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = (acc_q & ~(MASK << base))
              | (WIDTH'(ps) << base);
        c_d   = co;
        if (last) begin
          sum_d   = acc_d;
          cout_d  = co;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1])
                 && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_ripple_adder.sv
// Bench for serial_ripple_adder: three digit sizes
// share stimulus and are checked against a model.
module tb_serial_ripple_adder;
  localparam int W = 8;
  localparam int N = 3;

  function automatic int dig(input int i);
    case (i)
      0:       return 1;
      1:       return 4;
      default: return 8;
    endcase
  endfunction

  function automatic int steps(input int i);
    return W / dig(i);
  endfunction

  // {ovf, cout, sum} from plain integer arithmetic
  function automatic logic [W+1:0] ref_add(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic         c
  );
    int u;
    int s;
    logic ov;
    u  = int'(x) + int'(y) + int'(c);
    s  = int'($signed(x)) + int'($signed(y)) + int'(c);
    ov = (s > 127) || (s < -128);
    return {ov, u[W:0]};
  endfunction

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  logic         busy_v [N];
  logic         done_v [N];
  logic         cout_v [N];
  logic         ovf_v  [N];
  logic [W-1:0] sum_v  [N];

  for (genvar g = 0; g < N; g++) begin : gen_dut
    serial_ripple_adder_if #(.WIDTH(W)) bus ();
    assign bus.start = start;
    assign bus.a     = a;
    assign bus.b     = b;
    assign bus.cin   = cin;
    assign busy_v[g] = bus.busy;
    assign done_v[g] = bus.done;
    assign cout_v[g] = bus.cout;
    assign ovf_v[g]  = bus.ovf;
    assign sum_v[g]  = bus.sum;
    serial_ripple_adder #(
      .WIDTH(W),
      .DIGIT(dig(g))
    ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
    );
  end

  always #5 clk = ~clk;

  // Reference: a countdown of remaining cycles and a
  // pending result per instance.
  int           rem    [N];
  logic [W+1:0] pend   [N];
  logic         m_busy [N];
  logic         m_done [N];
  logic         m_cout [N];
  logic         m_ovf  [N];
  logic [W-1:0] m_sum  [N];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        rem[i]    <= 0;
        pend[i]   <= '0;
        m_busy[i] <= 1'b0;
        m_done[i] <= 1'b0;
        m_cout[i] <= 1'b0;
        m_ovf[i]  <= 1'b0;
        m_sum[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        m_done[i] <= 1'b0;
        if (rem[i] > 0) begin
          rem[i] <= rem[i] - 1;
          if (rem[i] == 1) begin
            {m_ovf[i], m_cout[i], m_sum[i]} <= pend[i];
            m_done[i] <= 1'b1;
            m_busy[i] <= 1'b0;
          end
        end else if (start) begin
          pend[i]   <= ref_add(a, b, cin);
          rem[i]    <= steps(i);
          m_busy[i] <= 1'b1;
        end
      end
    end
  end

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int opcyc = 0;
  int done_cnt  [N] = '{default: 0};
  int last_done [N] = '{default: 0};

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (done_v[i] === 1'b1) begin
        done_cnt[i]++;
        last_done[i] = cyc;
      end
      check($sformatf("dut%0d_outputs", i),
        32'({busy_v[i], done_v[i], cout_v[i],
             ovf_v[i], sum_v[i]}),
        32'({m_busy[i], m_done[i], m_cout[i],
             m_ovf[i], m_sum[i]}));
    end
  endtask

  task automatic op(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic         c
  );
    a = x;
    b = y;
    cin = c;
    start = 1'b1;
    tick();
    opcyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_op(input bit all);
    int n;
    n = 0;
    while (done_v[0] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("done_timeout", 32'(done_v[0]), 32'd1);
    for (int i = 0; i < N; i++) begin
      if (all || i == 0)
        check($sformatf("latency%0d", i),
              32'(last_done[i] - opcyc),
              32'(steps(i)));
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  localparam int NV = 8;
  vec_t vec [NV];

  initial begin
    logic [W+1:0] e;
    int d0;
    int prev;
    int n;

    vec[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vec[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vec[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vec[3] = '{8'h9A, 8'h76, 1'b1, 8'h11, 1'b1, 1'b0};
    vec[4] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
    vec[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vec[6] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};
    vec[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

    #1 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < N; i++) begin
      check("reset_busy", 32'(busy_v[i]), 32'd0);
      check("reset_sum", 32'(sum_v[i]), 32'd0);
    end

    for (int t = 0; t < NV; t++) begin
      op(vec[t].a, vec[t].b, vec[t].cin);
      wait_op(1'b1);
      for (int i = 0; i < N; i++) begin
        check($sformatf("vec%0d_sum", t),
              32'(sum_v[i]), 32'(vec[t].sum));
        check($sformatf("vec%0d_cout", t),
              32'(cout_v[i]), 32'(vec[t].cout));
        check($sformatf("vec%0d_ovf", t),
              32'(ovf_v[i]), 32'(vec[t].ovf));
      end
      tick();
    end

    for (int t = 0; t < 30; t++) begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         c;
      x = W'($urandom);
      y = W'($urandom);
      c = 1'($urandom);
      op(x, y, c);
      wait_op(1'b1);
      e = ref_add(x, y, c);
      check("rand_result",
            32'({ovf_v[0], cout_v[0], sum_v[0]}),
            32'(e));
      if ($urandom_range(1, 0) == 1) tick();
    end

    // start during RUN and operand churn are ignored
    op(8'h10, 8'h20, 1'b0);
    d0 = done_cnt[0];
    tick();
    tick();
    a = 8'hFF;
    b = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    tick();
    a = W'($urandom);
    wait_op(1'b0);
    check("midrun_sum", 32'(sum_v[0]), 32'h30);
    repeat (15) tick();
    check("midrun_one_done",
          32'(done_cnt[0] - d0), 32'd1);
    check("midrun_idle", 32'(busy_v[0]), 32'd0);

    // asynchronous reset in the middle of RUN
    op(8'h55, 8'h55, 1'b0);
    d0 = done_cnt[0];
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      check("rst_busy", 32'(busy_v[i]), 32'd0);
      check("rst_result",
            32'({ovf_v[i], cout_v[i], sum_v[i]}),
            32'd0);
    end
    tick();
    rst_n = 1'b1;
    repeat (12) tick();
    check("rst_no_done", 32'(done_cnt[0] - d0), 32'd0);
    op(8'h01, 8'h02, 1'b0);
    wait_op(1'b1);
    for (int i = 0; i < N; i++)
      check("after_rst_sum", 32'(sum_v[i]), 32'h03);
    tick();

    // back-to-back with start held high
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'b0;
    e = ref_add(a, b, cin);
    start = 1'b1;
    prev = -1;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (done_v[0] !== 1'b1 && n < 12) begin
        tick();
        n++;
      end
      check("b2b_timeout", 32'(done_v[0]), 32'd1);
      if (prev >= 0)
        check("b2b_period", 32'(cyc - prev), 32'd9);
      prev = cyc;
      check("b2b_result",
            32'({ovf_v[0], cout_v[0], sum_v[0]}),
            32'(e));
      a = (k % 2 == 0) ? 8'hC3 : W'($urandom);
      b = (k % 2 == 0) ? 8'h5A : W'($urandom);
      cin = ~cin;
      e = ref_add(a, b, cin);
      tick();
    end
    start = 1'b0;
    repeat (12) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/serial_ripple_adder.md
# serial_ripple_adder

Multi-cycle, parametrised ripple-carry adder. It adds two WIDTH-bit operands plus a carry-in over WIDTH/DIGIT clock cycles, processing DIGIT bits per cycle through a single DIGIT-bit full-adder chain. It is the sequential, area-reduced successor to the combinational half/full-adder RCA cells. It sits in datapaths where adder area matters more than latency, driven by a simple start/done handshake.

## Interface
- WIDTH, default 8: operand and sum width in bits. Must be at least 1.
- DIGIT, default 1: bits added per cycle. Must divide WIDTH exactly. STEPS = WIDTH/DIGIT.

Ports:
- clk, input, 1: single clock. All state changes occur on the rising edge.
- rst_n, input, 1: reset. Asynchronous, active-low.
- start, input, 1: request a new addition. Sampled only in IDLE.
- a, input, WIDTH: operand A. Captured when start is accepted.
- b, input, WIDTH: operand B. Captured when start is accepted.
- cin, input, 1: carry-in. Captured when start is accepted.
- busy, output, 1: high while an addition is in progress.
- done, output, 1: one-cycle pulse marking that the result is valid.
- sum, output, WIDTH: result register.
- cout, output, 1: carry out of the MSB.
- ovf, output, 1: two's-complement signed overflow.

## Operation
- States:
  - IDLE: waits for start.
  - RUN: adds one digit per cycle.
  - Return to IDLE happens on the completion edge.
- IDLE, start=1 at a rising edge:
  - Latch a, b and cin into internal registers.
  - Clear the digit counter cnt to 0 and load the carry register with cin.
  - Enter RUN.
- IDLE, start=0: no change.
- RUN, each edge:
  - Add digit cnt, i.e. bits [cnt*DIGIT +: DIGIT], of the latched A and B plus the carry register, producing a DIGIT-bit partial sum and a new carry.
  - Store the partial sum into the internal accumulator at the same slice.
  - Increment cnt.
- RUN, edge where cnt = STEPS-1:
  - Write the full accumulator, including this final digit, to sum.
  - Set cout = final carry.
  - Set ovf = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]).
  - Assert done for the next cycle and return to IDLE.
- start while in RUN is ignored. It is neither queued nor able to corrupt the latched operands.
- The a, b and cin inputs may change freely after acceptance without affecting the result.
- sum, cout and ovf change only on a completion edge. Between completions they hold their previous values, including throughout RUN.
- Arithmetic: {cout, sum} = A + B + cin, exact modulo 2^(WIDTH+1). No saturation.

## Timing
- Reset (rst_n=0, asynchronous, at any time including mid-RUN):
  - State goes to IDLE and cnt to 0.
  - busy=0, done=0, sum=0, cout=0, ovf=0.
  - The internal operand and carry registers are cleared.
  - An addition in progress is discarded and no done is produced.
- Start accepted at edge k:
  - busy=1 from edge k until edge k+STEPS, i.e. high for exactly STEPS cycles.
  - Result registers update at edge k+STEPS.
  - done=1 for exactly the one cycle following edge k+STEPS. busy=0 in that same cycle.
- Latency from start edge to result: STEPS cycles. With WIDTH=8, that is 8 cycles for DIGIT=1 and 2 cycles for DIGIT=4.
- Back-to-back operation: start held high during the done cycle is accepted at the next edge. Sustained throughput is one result per STEPS+1 cycles.
- WIDTH=DIGIT (STEPS=1): busy is high for 1 cycle and done pulses on the following cycle.
- done is never asserted for two consecutive cycles.

## Test plan
- WIDTH=8, DIGIT=1: reset, then start with a=0xFF, b=0x01, cin=0. Required: busy high for 8 cycles; done pulses once; sum=0x00, cout=1, ovf=0.
- WIDTH=8, DIGIT=1: a=0x7F, b=0x01, cin=0. Required: sum=0x80, cout=0, ovf=1. Then a=0x00, b=0x00, cin=1. Required: sum=0x01, cout=0, ovf=0.
- WIDTH=8, DIGIT=4: a=0x9A, b=0x76, cin=1. Required: done 2 cycles after acceptance; sum=0x11, cout=1, ovf=0.
- Start with a=0x10, b=0x20. Pulse start with a=0xFF, b=0xFF at cycle 3 of RUN, and change a and b mid-run. Required: a single done; sum=0x30; no second operation launched.
- Start with a=0x55, b=0x55, then drop rst_n at cycle 4 of RUN. Required: immediately busy=0 and sum=0, cout=0, ovf=0; done never pulses. After release, a=0x01, b=0x02 gives sum=0x03.
- Back-to-back: hold start=1 continuously with alternating operands. Required: a done every 9 cycles (DIGIT=1) and correct results for each operand pair; sum stable during each RUN.
